// File: rtl/sopc_data_bus_ic_pkg.sv
// Shared state encoding and sizing constants for the SOPC data-bus interconnect.
package sopc_data_bus_ic_pkg;

    typedef enum logic [1:0] {
        BusIdle = 2'd0,
        BusBusy = 2'd1,
        BusDone = 2'd2
    } bus_state_e;

    // Wide enough to index up to 8 slaves.
    localparam int unsigned SlaveIdxW      = 3;
    localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/sopc_addr_decoder.sv
// Combinational address decoder: full 32-bit (addr & mask) == base match, lowest slave index wins.
module sopc_addr_decoder
    import sopc_data_bus_ic_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = '0,
    parameter logic [32*NUM_SLAVES-1:0] MASK_ADDRS = '0
) (
    input  logic [31:0]          addr,
    output logic                 hit,
    output logic [SlaveIdxW-1:0] idx
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((addr & MASK_ADDRS[i*32 +: 32]) == BASE_ADDRS[i*32 +: 32]) begin
                hit = 1'b1;
                idx = SlaveIdxW'(i);
            end
        end
    end

endmodule

// File: rtl/sopc_data_bus_ic.sv
// Data-bus interconnect: decodes core data-port accesses onto one of NUM_SLAVES slaves with
// wait-state handshake, slave timeout and a one-cycle bus-error pulse.
module sopc_data_bus_ic
    import sopc_data_bus_ic_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0] MASK_ADDRS = {NUM_SLAVES{32'hF000_0000}},
    parameter int unsigned              TIMEOUT    = DefaultTimeout,
    parameter int unsigned              TO_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ram_ce_i,
    input  logic                       ram_we_i,
    input  logic [31:0]                ram_addr_i,
    input  logic [3:0]                 ram_sel_i,
    input  logic [31:0]                ram_data_i,
    output logic [31:0]                ram_data_o,
    output logic                       stall_req_o,
    output logic                       bus_err_o,
    output logic [NUM_SLAVES-1:0]      s_ce_o,
    output logic                       s_we_o,
    output logic [31:0]                s_addr_o,
    output logic [3:0]                 s_sel_o,
    output logic [31:0]                s_data_o,
    input  logic [32*NUM_SLAVES-1:0]   s_data_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i
);

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    bus_state_e           state_q;
    logic [SlaveIdxW-1:0] idx_q;
    logic [TO_W-1:0]      cnt_q;

    logic                 dec_hit;
    logic [SlaveIdxW-1:0] dec_idx;
    logic                 ack_sel;
    logic [31:0]          rd_data;

    sopc_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDRS (BASE_ADDRS),
        .MASK_ADDRS (MASK_ADDRS)
    ) u_decoder (
        .addr (ram_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the selected slave's ack and data are visible; stray acks are dropped here.
    always_comb begin
        ack_sel = 1'b0;
        rd_data = '0;
        s_ce_o  = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_q == SlaveIdxW'(i)) begin
                ack_sel   = s_ack_i[i];
                rd_data   = s_data_i[i*32 +: 32];
                s_ce_o[i] = (state_q == BusBusy);
            end
        end
    end

    always_comb begin
        stall_req_o = 1'b0;
        unique case (state_q)
            BusIdle: stall_req_o = ram_ce_i;
            BusBusy: stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BusIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_sel_o    <= '0;
            s_data_o   <= '0;
            ram_data_o <= '0;
            bus_err_o  <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            unique case (state_q)
                BusIdle: begin
                    if (ram_ce_i) begin
                        if (dec_hit) begin
                            s_we_o   <= ram_we_i;
                            s_addr_o <= ram_addr_i;
                            s_sel_o  <= ram_sel_i;
                            s_data_o <= ram_data_i;
                            idx_q    <= dec_idx;
                            cnt_q    <= '0;
                            state_q  <= BusBusy;
                        end else begin
                            ram_data_o <= '0;
                            bus_err_o  <= 1'b1;
                            state_q    <= BusDone;
                        end
                    end
                end
                BusBusy: begin
                    if (ack_sel) begin
                        ram_data_o <= s_we_o ? 32'h0 : rd_data;
                        state_q    <= BusDone;
                    end else if (cnt_q == ToLast) begin
                        ram_data_o <= '0;
                        bus_err_o  <= 1'b1;
                        state_q    <= BusDone;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                BusDone: state_q <= BusIdle;
                default: state_q <= BusIdle;
            endcase
        end
    end

endmodule
